if_prefetch_unit: RTL and testbench
===================================

# if_prefetch_unit

Parametrised instruction-fetch front end for the pipelined MIPS core. It replaces the bare PC register and IF/ID latch with a fetch engine that tolerates multi-cycle instruction memory, and it buffers fetched words in a DEPTH-entry prefetch queue. Fetch continues while the decode stage is paused. Redirects from ID/CP0 (branch, jump, EPC, exception vector) flush the queue and discard any response still in flight.

## Interface
- `ADDR_W`, default 32: instruction address width.
- `DEPTH`, default 4: prefetch queue entries; a power of 2, at least 2.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `redirect_i` in 1: flush the queue and restart fetch at `redirect_pc_i`.
- `redirect_pc_i` in ADDR_W: new fetch address; bits [1:0] are ignored and treated as 0.
- `im_req_o` out 1: instruction memory request.
- `im_adr_o` out ADDR_W: request address; held stable while `im_req_o`=1 and `im_ack_i`=0.
- `im_ack_i` in 1: memory completes the request this cycle; `im_dat_i` is valid.
- `im_dat_i` in 32: instruction word.
- `id_valid_o` out 1: the queue head is valid.
- `id_ready_i` in 1: ID consumes the head when `id_valid_o`=1 and `id_ready_i`=1. Driven low on pipeline pause.
- `id_instr_o` out 32: instruction at the queue head.
- `id_pc_o` out ADDR_W: PC of the head instruction.
- `id_pc_4_o` out ADDR_W: `id_pc_o`+4, modulo 2^ADDR_W.
- `fifo_count_o` out $clog2(DEPTH+1): number of occupied entries.

## Operation
- **State machine: IDLE, WAIT, DROP.** At most one request is outstanding.
  - IDLE: drive `im_req_o`=1 whenever `count + 0 < DEPTH`, meaning a slot is free for the response.
  - Ack in the same cycle: push {`im_dat_i`, `fetch_pc`}, set `fetch_pc += 4`, stay in IDLE.
  - No ack: go to WAIT.
- **WAIT:** hold `im_req_o`=1 and `im_adr_o`=`fetch_pc`. On ack, push, increment `fetch_pc`, and go to IDLE.
- **DROP:** a redirect arrived while a request was outstanding.
  - Keep `im_req_o`/`im_adr_o` at the old address until ack, because the memory protocol forbids abort.
  - Discard the data.
  - On ack, go to IDLE with `fetch_pc` equal to the saved redirect PC.
- **Slot reservation:** the in-flight request counts as occupancy, so a push can never overflow the queue. With simultaneous push and pop, `count` is unchanged.
- **Redirect** (priority over every other event in that cycle):
  - The queue is cleared next cycle (`count`=0, `id_valid_o`=0).
  - A pop in the same cycle is accepted by ID, then the queue is cleared.
  - In IDLE, or in WAIT/IDLE with an ack the same cycle: `fetch_pc`←`{redirect_pc_i[ADDR_W-1:2],2'b00}`, state IDLE, and any acked data is discarded.
  - In WAIT without an ack: save the PC and go to DROP.
  - In DROP: overwrite the saved PC; the last redirect wins.
- **Queue:** circular buffer with read and write pointers of $clog2(DEPTH) bits, wrapping naturally. The head outputs come directly from the storage at the read pointer.
- **Addresses:** `fetch_pc` wraps modulo 2^ADDR_W with no fault.

## Timing
- **Reset values:**
  - `im_req_o`=0 and `im_adr_o`=RESET_PC.
  - `id_valid_o`=0, `id_instr_o`=0, `id_pc_o`=RESET_PC, `id_pc_4_o`=RESET_PC+4.
  - `fifo_count_o`=0, state IDLE.
- **First request:** the first rising edge after `reset` deasserts sees `im_req_o`=1 at RESET_PC.
- **Latency:** a request acked in cycle N gives `id_valid_o`=1 in cycle N+1.
- **Redirect in cycle N** with no outstanding request: request at the new PC in cycle N+1; with zero-wait memory, `id_valid_o` in N+2.
- **Throughput:** one instruction per cycle with zero-wait memory and `id_ready_i`=1.
- **Reset asserted mid-WAIT or mid-DROP:** everything returns to reset values immediately. Outstanding memory state is the memory's responsibility.
- **Outputs:** `im_req_o` and `im_adr_o` depend only on state, count and `fetch_pc`, never combinationally on `im_ack_i` or `redirect_i`.

## Test plan
- **Reset then stream.** Release reset; zero-wait ack; `id_ready_i`=1.
  - Required: fetch addresses 0, 4, 8, … one per cycle.
  - Required: `id_pc_o` sequence 0, 4, 8 with `id_pc_4_o` = `id_pc_o`+4.
  - Required: `fifo_count_o` never exceeds 1.
- **Backpressure fill.** `id_ready_i`=0, zero-wait memory.
  - Required: exactly DEPTH=4 words pushed and `fifo_count_o`=4.
  - Required: `im_req_o` drops to 0.
  - Raise ready: entries drain in order, then fetch resumes at 0x10.
- **Wait states.** Ack 3 cycles after each request.
  - Required: `im_adr_o` stable during WAIT.
  - Required: one instruction per 4 cycles, with correct PCs.
- **Redirect during WAIT.** Request 0x8 outstanding; `redirect_i` to 0x100.
  - Required: state DROP and the 0x8 data discarded.
  - Required: next request at 0x100, and the first valid head has `id_pc_o`=0x100.
- **Redirect with a full queue and a simultaneous pop.**
  - Required: the pop is accepted.
  - Required: `fifo_count_o`=0 next cycle, then a request at `redirect_pc_i` & ~3 (e.g. 0x203 gives 0x200).
- **Wrap-around.** RESET_PC=32'hFFFF_FFF8, zero-wait memory.
  - Required: fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - Required: `id_pc_4_o` for FFFF_FFFC = 0.

Source files
------------

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: one-outstanding-request fetch engine feeding a
// DEPTH-entry prefetch queue, with redirect flush and in-flight response drop.
module if_prefetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_i,
  input  logic [ADDR_W-1:0]          redirect_pc_i,
  output logic                       im_req_o,
  output logic [ADDR_W-1:0]          im_adr_o,
  input  logic                       im_ack_i,
  input  logic [31:0]                im_dat_i,
  output logic                       id_valid_o,
  input  logic                       id_ready_i,
  output logic [31:0]                id_instr_o,
  output logic [ADDR_W-1:0]          id_pc_o,
  output logic [ADDR_W-1:0]          id_pc_4_o,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [ADDR_W-1:0] r_redir_pc, w_redir_pc_nxt;
  logic [ADDR_W-1:0] w_redir_pc;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     r_rd_ptr, r_wr_ptr;
  logic [31:0]       r_mem_instr [DEPTH];
  logic [ADDR_W-1:0] r_mem_pc    [DEPTH];
  logic              w_req, w_ack, w_push, w_pop;
  logic              w_unused_pc_lsb;

  assign w_redir_pc      = {redirect_pc_i[ADDR_W-1:2], 2'b00};
  assign w_unused_pc_lsb = ^redirect_pc_i[1:0];

  // An outstanding request always owns a free slot, so issue only with room.
  assign w_req = (r_state != S_IDLE) || (r_count < CW'(DEPTH));
  assign w_ack = w_req & im_ack_i;
  assign w_pop = id_valid_o & id_ready_i;

  assign im_req_o     = w_req & reset;
  assign im_adr_o     = r_fetch_pc;
  assign id_valid_o   = (r_count != '0);
  assign id_instr_o   = r_mem_instr[r_rd_ptr];
  assign id_pc_o      = r_mem_pc[r_rd_ptr];
  assign id_pc_4_o    = id_pc_o + ADDR_W'(4);
  assign fifo_count_o = r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_redir_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_redir_pc <= w_redir_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_redir_pc_nxt = r_redir_pc;
    w_push         = 1'b0;
    case (r_state)
      S_IDLE, S_WAIT: begin
        if (redirect_i) begin
          // A request the memory has not yet completed cannot be aborted.
          if (w_req && !w_ack) begin
            w_redir_pc_nxt = w_redir_pc;
            w_state_nxt    = S_DROP;
          end else begin
            w_fetch_pc_nxt = w_redir_pc;
            w_state_nxt    = S_IDLE;
          end
        end else if (w_ack) begin
          w_push         = 1'b1;
          w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(4);
          w_state_nxt    = S_IDLE;
        end else if (w_req) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DROP: begin
        if (redirect_i && w_ack) begin
          w_fetch_pc_nxt = w_redir_pc;
          w_state_nxt    = S_IDLE;
        end else if (redirect_i) begin
          w_redir_pc_nxt = w_redir_pc;
        end else if (w_ack) begin
          w_fetch_pc_nxt = r_redir_pc;
          w_state_nxt    = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_instr[i] <= '0;
        r_mem_pc[i]    <= RESET_PC;
      end
    end else if (redirect_i) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem_instr[r_wr_ptr] <= im_dat_i;
        r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
        r_wr_ptr              <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: transaction-level queue model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_if_prefetch_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  always #5 clk = ~clk;

  logic        redirect_i, im_req_o, im_ack_i, id_valid_o, id_ready_i;
  logic [31:0] redirect_pc_i, im_adr_o, im_dat_i, id_instr_o, id_pc_o, id_pc_4_o;
  logic [2:0]  fifo_count_o;

  logic        w2_req, w2_valid;
  logic [31:0] w2_adr, w2_dat, w2_instr, w2_pc, w2_pc4;
  logic [2:0]  w2_cnt;

  int total = 0;
  int bad   = 0;
  int ws    = 0;
  int wcnt  = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  assign w2_dat = memf(w2_adr);

  if_prefetch_unit #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .im_req_o(im_req_o), .im_adr_o(im_adr_o), .im_ack_i(im_ack_i), .im_dat_i(im_dat_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_instr_o(id_instr_o),
    .id_pc_o(id_pc_o), .id_pc_4_o(id_pc_4_o), .fifo_count_o(fifo_count_o));

  if_prefetch_unit #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .reset(reset), .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .im_req_o(w2_req), .im_adr_o(w2_adr), .im_ack_i(1'b1), .im_dat_i(w2_dat),
    .id_valid_o(w2_valid), .id_ready_i(1'b1), .id_instr_o(w2_instr),
    .id_pc_o(w2_pc), .id_pc_4_o(w2_pc4), .fifo_count_o(w2_cnt));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model: queue of delivered {instr,pc}, next PC to fetch, and the one
  // request in flight (with a flag saying its data must be thrown away).
  typedef struct packed {logic [31:0] instr; logic [31:0] pc;} ent_t;
  ent_t        mq[$];
  logic [31:0] m_next = 32'h0;
  logic [31:0] m_iadr = 32'h0;
  logic [31:0] m_save = 32'h0;
  bit          m_infl = 1'b0;
  bit          m_disc = 1'b0;

  function automatic bit m_req();
    return m_infl || (mq.size() < DEPTH);
  endfunction

  initial forever begin : model
    bit          rq;
    logic [31:0] ad;
    ent_t        e;
    @(posedge clk);
    if (!reset) begin
      mq.delete();
      m_next = 32'h0; m_infl = 1'b0; m_disc = 1'b0; m_iadr = 32'h0; m_save = 32'h0;
    end else begin
      rq = m_req();
      ad = m_infl ? m_iadr : m_next;
      if (mq.size() > 0 && id_ready_i) void'(mq.pop_front());
      if (rq && im_ack_i) begin
        if (!m_disc && !redirect_i) begin
          e.instr = memf(ad);
          e.pc    = ad;
          mq.push_back(e);
        end
        m_next = m_disc ? m_save : ad + 32'd4;
        m_infl = 1'b0;
        m_disc = 1'b0;
      end else if (rq) begin
        m_infl = 1'b1;
        m_iadr = ad;
      end
      if (redirect_i) begin
        mq.delete();
        if (m_infl) begin
          m_disc = 1'b1;
          m_save = redirect_pc_i & ~32'd3;
        end else begin
          m_next = redirect_pc_i & ~32'd3;
        end
      end
    end
  end

  initial forever begin : compare
    @(negedge clk);
    if (!reset) begin
      chk("rst_req", 32'(im_req_o), 32'd0);
      chk("rst_cnt", 32'(fifo_count_o), 32'd0);
      chk("rst_vld", 32'(id_valid_o), 32'd0);
    end else begin
      chk("req", 32'(im_req_o), 32'(m_req()));
      chk("adr", im_adr_o, m_infl ? m_iadr : m_next);
      chk("cnt", 32'(fifo_count_o), 32'(mq.size()));
      chk("vld", 32'(id_valid_o), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("instr", id_instr_o, mq[0].instr);
        chk("pc", id_pc_o, mq[0].pc);
        chk("pc4", id_pc_4_o, mq[0].pc + 32'd4);
      end
    end
  end

  // Memory: acks after ws idle cycles of an asserted request.
  initial begin : memory
    im_ack_i = 1'b0;
    im_dat_i = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (reset && im_req_o) begin
        if (wcnt >= ws) begin
          im_ack_i = 1'b1;
          im_dat_i = memf(im_adr_o);
          wcnt     = 0;
        end else begin
          im_ack_i = 1'b0;
          im_dat_i = 32'hDEAD_BEEF;
          wcnt++;
        end
      end else begin
        im_ack_i = 1'b0;
        wcnt     = 0;
      end
    end
  end

  initial begin : stim
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    id_ready_i    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_adr", im_adr_o, 32'h0);
    chk("rst_instr", id_instr_o, 32'h0);
    chk("rst_pc", id_pc_o, 32'h0);
    chk("rst_pc4", id_pc_4_o, 32'h4);
    chk("w_rst_adr", w2_adr, 32'hFFFF_FFF8);
    chk("w_rst_pc4", w2_pc4, 32'hFFFF_FFFC);

    // Reset then stream
    id_ready_i = 1'b1;
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("s_req0", 32'(im_req_o), 32'd1);
    chk("s_adr0", im_adr_o, 32'h0);
    chk("w_adr0", w2_adr, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("s_adr1", im_adr_o, 32'h4);
    chk("s_pc0", id_pc_o, 32'h0);
    chk("s_pc4_0", id_pc_4_o, 32'h4);
    chk("w_adr1", w2_adr, 32'hFFFF_FFFC);
    chk("w_pc0", w2_pc, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("s_adr2", im_adr_o, 32'h8);
    chk("s_pc1", id_pc_o, 32'h4);
    chk("s_pc4_1", id_pc_4_o, 32'h8);
    chk("w_adr2", w2_adr, 32'h0);
    chk("w_pc1", w2_pc, 32'hFFFF_FFFC);
    chk("w_pc4_1", w2_pc4, 32'h0);
    repeat (5) begin
      @(negedge clk);
      total++;
      if (fifo_count_o > 3'd1) begin
        bad++;
        $display("FAIL stream_cnt: got %0d want <=1", fifo_count_o);
      end
    end

    // Backpressure fill from a clean start at 0
    id_ready_i    = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0;
    @(negedge clk);
    redirect_i = 1'b0;
    chk("bp_cnt0", 32'(fifo_count_o), 32'd0);
    chk("bp_adr0", im_adr_o, 32'h0);
    repeat (4) @(negedge clk);
    chk("bp_full", 32'(fifo_count_o), 32'd4);
    chk("bp_req", 32'(im_req_o), 32'd0);
    chk("bp_adr", im_adr_o, 32'h10);
    chk("bp_head", id_pc_o, 32'h0);
    repeat (2) @(negedge clk);
    chk("bp_hold", 32'(fifo_count_o), 32'd4);
    id_ready_i = 1'b1;
    @(negedge clk);
    chk("dr_head1", id_pc_o, 32'h4);
    chk("dr_req", 32'(im_req_o), 32'd1);
    chk("dr_adr", im_adr_o, 32'h10);
    repeat (3) @(negedge clk);
    chk("dr_resume", id_pc_o, 32'h10);
    id_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("refill", 32'(fifo_count_o), 32'd4);
    chk("refill_req", 32'(im_req_o), 32'd0);
    ws = 3;

    // Redirect with full queue and simultaneous pop, then wait-state fetch
    @(negedge clk);
    chk("rf_full", 32'(fifo_count_o), 32'd4);
    id_ready_i    = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h203;
    @(negedge clk);
    redirect_i = 1'b0;
    chk("rf_cnt", 32'(fifo_count_o), 32'd0);
    chk("rf_vld", 32'(id_valid_o), 32'd0);
    chk("rf_adr", im_adr_o, 32'h200);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ws_stable", im_adr_o, 32'h200);
    end
    @(negedge clk);
    chk("ws_vld0", 32'(id_valid_o), 32'd1);
    chk("ws_pc0", id_pc_o, 32'h200);
    chk("ws_adr1", im_adr_o, 32'h204);
    repeat (4) @(negedge clk);
    chk("ws_pc1", id_pc_o, 32'h204);
    chk("ws_pc4_1", id_pc_4_o, 32'h208);
    chk("ws_adr2", im_adr_o, 32'h208);

    // Redirects during WAIT and during DROP; last one wins
    @(negedge clk);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    chk("dp_adr", im_adr_o, 32'h208);
    @(negedge clk);
    redirect_pc_i = 32'h300;
    chk("dp_hold0", im_adr_o, 32'h208);
    chk("dp_req", 32'(im_req_o), 32'd1);
    @(negedge clk);
    redirect_i = 1'b0;
    chk("dp_hold1", im_adr_o, 32'h208);
    @(negedge clk);
    chk("dp_new_adr", im_adr_o, 32'h300);
    chk("dp_vld", 32'(id_valid_o), 32'd0);
    repeat (4) @(negedge clk);
    chk("dp_first_vld", 32'(id_valid_o), 32'd1);
    chk("dp_first_pc", id_pc_o, 32'h300);

    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
